// File: rtl/serial_sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | serial_sub_pkg : shared constants and FSM encoding              |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package serial_sub_pkg;

  localparam int DEF_WIDTH = 32;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  localparam int NIB_COUNT = nib_count(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------+
// | serial_subtractor_if : request/result bundle for the subtractor |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, signed_op,
    input  busy, done, diff, borrow, overflow, zero
  );

  modport slave (
    input  start, a, b, signed_op,
    output busy, done, diff, borrow, overflow, zero
  );
endinterface
`default_nettype wire

// File: rtl/nibble_sub_slice.sv
`default_nettype none
// +----------------------------------------------------------------+
// | nibble_sub_slice : 4-bit a + ~b + cin, combinational            |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module nibble_sub_slice (
  input  wire logic [3:0] i_a,
  input  wire logic [3:0] i_b,
  input  wire logic       i_cin,
  output logic      [3:0] o_sum,
  output logic            o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, ~i_b} + {4'b0000, i_cin};
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------+
// | serial_subtractor : nibble-serial a - b with borrow/ovf/zero    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input wire logic          clk,
  input wire logic          rst,
  serial_subtractor_if.slave bus
);
  localparam int NIBS  = nib_count(WIDTH);
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_sop;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_done;
  logic             r_borrow;
  logic             r_overflow;
  logic             r_zero;
  logic [3:0]       w_sum;
  logic             w_cout;
  logic             w_last;

  nibble_sub_slice u_slice (
    .i_a    (r_a[3:0]),
    .i_b    (r_b[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_last = (r_idx == IDX_W'(NIBS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_FIN;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Flags are resolved in FIN and registered together with done on the exit edge,
  // so during RUN they keep the previous result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_diff     <= '0;
      r_sop      <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sop   <= bus.signed_op;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_carry <= 1'b1;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          r_diff  <= {w_sum, r_diff[WIDTH-1:4]};
          r_carry <= w_cout;
          r_idx   <= r_idx + IDX_W'(1);
        end
        ST_FIN: begin
          r_done     <= 1'b1;
          r_borrow   <= ~r_carry;
          r_zero     <= (r_diff == '0);
          r_overflow <= r_sop && (r_a_msb != r_b_msb) && (r_diff[WIDTH-1] != r_a_msb);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.diff     = r_diff;
  assign bus.borrow   = r_borrow;
  assign bus.overflow = r_overflow;
  assign bus.zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_serial_subtractor : directed vector bench for the subtractor |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_serial_subtractor;
  localparam int W       = 32;
  localparam int EXP_LAT = 9;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sop;
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    logic         z;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  vec_t vecs [9];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.signed_op = sop;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] held;
    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.signed_op = 1'b0;
    #1;
    chk("reset_ctrl", 32'({bus.busy, bus.done, bus.borrow, bus.overflow, bus.zero}), 32'd0);
    chk("reset_diff", bus.diff, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sop);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(EXP_LAT));
      chk($sformatf("v%0d_diff", i), bus.diff, vecs[i].d);
      chk($sformatf("v%0d_flags", i), 32'({bus.borrow, bus.overflow, bus.zero}),
          32'({vecs[i].br, vecs[i].ov, vecs[i].z}));
      held = bus.diff;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      chk($sformatf("v%0d_hold", i), bus.diff, held);
    end

    // Extra start and operand changes mid-operation must be ignored.
    start_op(32'h1234_5678, 32'h1234_5678, 1'b0);
    pulses = 0;
    lat    = -1;
    held   = 32'hDEAD_BEEF;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        bus.start     = 1'b1;
        bus.a         = 32'h0000_0001;
        bus.b         = 32'h0000_0002;
        bus.signed_op = 1'b1;
      end
      if (k == 4) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        lat  = k;
        held = {bus.diff[W-1:1], bus.zero};
      end
    end
    chk("busy_start_pulses", 32'(pulses), 32'd1);
    chk("busy_start_lat", 32'(lat), 32'(EXP_LAT));
    chk("busy_start_result", held, 32'h0000_0001);

    // Start arriving on the FIN->IDLE edge is dropped.
    start_op(32'h0000_0005, 32'h0000_0003, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("fin_start_done", 32'(bus.done), 32'd1);
    chk("fin_start_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk("fin_start_idle", 32'(bus.busy), 32'd0);

    // Leave nonzero flags, then abort mid-RUN with an asynchronous reset.
    start_op(32'h0000_0000, 32'h0000_0001, 1'b0);
    wait_done(lat);
    start_op(32'h0000_0005, 32'h0000_0003, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ctrl", 32'({bus.busy, bus.done, bus.borrow, bus.overflow, bus.zero}), 32'd0);
    chk("abort_diff", bus.diff, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    start_op(32'h0000_0009, 32'h0000_0004, 1'b0);
    wait_done(lat);
    chk("after_abort_lat", 32'(lat), 32'(EXP_LAT));
    chk("after_abort_diff", bus.diff, 32'h0000_0005);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
